// File: rtl/btb_table_pkg.sv
// Shared constants for the branch target buffer: counter states,
// outcome flags and the direction-counter width.
package btb_table_pkg;

   localparam int BUS_PRE_STATE = 2;

   localparam logic [BUS_PRE_STATE-1:0] STATE_S_HOLD = 2'b00;
   localparam logic [BUS_PRE_STATE-1:0] STATE_W_HOLD = 2'b01;
   localparam logic [BUS_PRE_STATE-1:0] STATE_W_JMP  = 2'b10;
   localparam logic [BUS_PRE_STATE-1:0] STATE_S_JMP  = 2'b11;

   localparam logic JMP_EN    = 1'b1;
   localparam logic JMP_DIS   = 1'b0;
   localparam logic JMP_RIGHT = 1'b0;
   localparam logic JMP_ERROR = 1'b1;

endpackage

// File: rtl/btb_counter.sv
// 2-bit saturating direction counter next-state: taken counts up,
// not-taken counts down, both clamp at the ends instead of wrapping.
module btb_counter
   import btb_table_pkg::*;
(
   input  logic [BUS_PRE_STATE-1:0] ctr,
   input  logic                     taken,
   output logic [BUS_PRE_STATE-1:0] ctr_nxt
);

   always_comb begin
      ctr_nxt = ctr;
      if (taken == JMP_EN) begin
         if (ctr != STATE_S_JMP) ctr_nxt = ctr + 2'b01;
      end else begin
         if (ctr != STATE_S_HOLD) ctr_nxt = ctr - 2'b01;
      end
   end

endmodule

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer. Combinational lookup on the fetch PC,
// one-stage prediction pipe, misprediction check and table training.
module btb_table
   import btb_table_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int ENTRIES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hold_i,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              resolve_valid_i,
   input  logic [ADDR_W-1:0] pc_jmp_i,
   input  logic [ADDR_W-1:0] target_pc_i,
   input  logic              jmp_en_i,
   output logic              jmp_prediction_o,
   output logic [ADDR_W-1:0] target_pc_o,
   output logic              prediction_error_o
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = ADDR_W - IDX_W - 2;

   typedef struct packed {
      logic              pred;
      logic [ADDR_W-1:0] tgt;
   } pipe_t;

   // Flop arrays: the lookup reads asynchronously, so no RAM inference.
   logic [ENTRIES-1:0]                    valid_q;
   logic [ENTRIES-1:0][TAG_W-1:0]         tag_q;
   logic [ENTRIES-1:0][ADDR_W-1:0]        target_q;
   logic [ENTRIES-1:0][BUS_PRE_STATE-1:0] ctr_q;
   pipe_t                                 pipe_q;

   logic [IDX_W-1:0]         rd_idx, wr_idx;
   logic [TAG_W-1:0]         rd_tag, wr_tag;
   logic                     rd_hit, wr_hit, train;
   logic [BUS_PRE_STATE-1:0] ctr_nxt;
   logic                     unused_lsb;

   // Instruction-aligned PCs: the two low bits carry no information.
   assign unused_lsb = ^{pc_i[1:0], pc_jmp_i[1:0]};

   assign rd_idx = pc_i[IDX_W+1:2];
   assign rd_tag = pc_i[ADDR_W-1:IDX_W+2];
   assign wr_idx = pc_jmp_i[IDX_W+1:2];
   assign wr_tag = pc_jmp_i[ADDR_W-1:IDX_W+2];

   assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag) && (pc_i != '0);
   assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
   assign train  = resolve_valid_i && (pc_jmp_i != '0);

   assign jmp_prediction_o = rd_hit && ctr_q[rd_idx][1];
   assign target_pc_o      = jmp_prediction_o ? target_q[rd_idx] : '0;

   btb_counter u_counter (
      .ctr     (ctr_q[wr_idx]),
      .taken   (jmp_en_i),
      .ctr_nxt (ctr_nxt)
   );

   // Tag and target need no reset: they are only read behind valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         ctr_q   <= {ENTRIES{STATE_W_HOLD}};
      end else if (train) begin
         if (jmp_en_i == JMP_EN) begin
            valid_q[wr_idx]  <= 1'b1;
            tag_q[wr_idx]    <= wr_tag;
            target_q[wr_idx] <= target_pc_i;
            ctr_q[wr_idx]    <= wr_hit ? ctr_nxt : STATE_W_JMP;
         end else if (wr_hit) begin
            ctr_q[wr_idx] <= ctr_nxt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i)
         pipe_q <= '0;
      else if (!hold_i)
         pipe_q <= '{pred: jmp_prediction_o, tgt: target_pc_o};
   end

   always_comb begin
      prediction_error_o = JMP_RIGHT;
      if (resolve_valid_i) begin
         if (jmp_en_i != pipe_q.pred)
            prediction_error_o = JMP_ERROR;
         else if (jmp_en_i && (target_pc_i != pipe_q.tgt))
            prediction_error_o = JMP_ERROR;
      end
   end

endmodule

// File: tb/tb_btb_table.sv
// Directed bench for btb_table: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_btb_table;

   localparam logic [31:0] PC_A = 32'h8000_0010;   // idx 4
   localparam logic [31:0] PC_B = 32'h8000_0050;   // idx 4, other tag
   localparam logic [31:0] PC_C = 32'h8000_0020;   // idx 8
   localparam logic [31:0] T1   = 32'h8000_0100;
   localparam logic [31:0] T2   = 32'h8000_0200;

   logic        clk = 1'b0;
   logic        rst, hold_i, flush_i, resolve_valid_i, jmp_en_i;
   logic [31:0] pc_i, pc_jmp_i, target_pc_i, target_pc_o;
   logic        jmp_prediction_o, prediction_error_o;

   typedef struct {
      int          id;
      logic        pred;
      logic [31:0] tgt;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   btb_table #(.ADDR_W(32), .ENTRIES(16)) dut (
      .clk                (clk),
      .rst                (rst),
      .hold_i             (hold_i),
      .flush_i            (flush_i),
      .pc_i               (pc_i),
      .resolve_valid_i    (resolve_valid_i),
      .pc_jmp_i           (pc_jmp_i),
      .target_pc_i        (target_pc_i),
      .jmp_en_i           (jmp_en_i),
      .jmp_prediction_o   (jmp_prediction_o),
      .target_pc_o        (target_pc_o),
      .prediction_error_o (prediction_error_o)
   );

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         checks = checks + 3;
         if (jmp_prediction_o !== e.pred) begin
            errors = errors + 1;
            $display("FAIL step%0d pred: got %b want %b", e.id, jmp_prediction_o, e.pred);
         end
         if (target_pc_o !== e.tgt) begin
            errors = errors + 1;
            $display("FAIL step%0d target: got %h want %h", e.id, target_pc_o, e.tgt);
         end
         if (prediction_error_o !== e.err) begin
            errors = errors + 1;
            $display("FAIL step%0d error: got %b want %b", e.id, prediction_error_o, e.err);
         end
      end
   end

   task automatic step(input int id, input logic r, input logic h, input logic f,
                       input logic [31:0] pc, input logic rv, input logic [31:0] pj,
                       input logic [31:0] tg, input logic en,
                       input logic ep, input logic [31:0] et, input logic ee);
      exp_t e;
      rst = r; hold_i = h; flush_i = f; pc_i = pc;
      resolve_valid_i = rv; pc_jmp_i = pj; target_pc_i = tg; jmp_en_i = en;
      e.id = id; e.pred = ep; e.tgt = et; e.err = ee;
      exp_q.push_back(e);
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; hold_i = 1'b0; flush_i = 1'b0; pc_i = PC_A;
      resolve_valid_i = 1'b0; pc_jmp_i = '0; target_pc_i = '0; jmp_en_i = 1'b0;
      @(posedge clk); #1;
      //     id r h f  pc    rv pc_jmp  tgt en   pred tgt  err
      step( 1, 1,0,0, PC_A, 0, '0,   '0, 0,   0, '0, 0);
      // Allocate, then climb to strong taken and saturate.
      step( 2, 0,0,0, PC_A, 1, PC_A, T1, 1,   0, '0, 1);
      step( 3, 0,0,0, PC_A, 0, '0,   '0, 0,   1, T1, 0);
      step( 4, 0,0,0, PC_A, 1, PC_A, T1, 1,   1, T1, 0);
      step( 5, 0,0,0, PC_A, 1, PC_A, T1, 1,   1, T1, 0);
      // 11 -> 10 -> 01 -> 00 -> 00 (floor), then back up.
      step( 6, 0,0,0, PC_A, 1, PC_A, '0, 0,   1, T1, 1);
      step( 7, 0,0,0, PC_A, 1, PC_A, '0, 0,   1, T1, 1);
      step( 8, 0,0,0, PC_A, 1, PC_A, '0, 0,   0, '0, 1);
      step( 9, 0,0,0, PC_A, 1, PC_A, '0, 0,   0, '0, 0);
      step(10, 0,0,0, PC_A, 1, PC_A, T1, 1,   0, '0, 1);
      step(11, 0,0,0, PC_A, 1, PC_A, T1, 1,   0, '0, 1);
      step(12, 0,0,0, PC_A, 0, '0,   '0, 0,   1, T1, 0);
      // Conflict at idx 4: B evicts A.
      step(13, 0,0,0, PC_B, 1, PC_B, T2, 1,   0, '0, 1);
      step(14, 0,0,0, PC_A, 0, '0,   '0, 0,   0, '0, 0);
      step(15, 0,0,0, PC_B, 0, '0,   '0, 0,   1, T2, 0);
      // Re-allocate A, then retarget it; lookup in the training cycle sees old data.
      step(16, 0,0,0, PC_A, 1, PC_A, T1, 1,   0, '0, 1);
      step(17, 0,0,0, PC_A, 0, '0,   '0, 0,   1, T1, 0);
      step(18, 0,0,0, PC_A, 1, PC_A, T2, 1,   1, T1, 1);
      step(19, 0,0,0, PC_A, 0, '0,   '0, 0,   1, T2, 0);
      step(20, 0,0,0, PC_A, 1, PC_A, '0, 0,   1, T2, 1);
      step(21, 0,0,0, PC_A, 0, '0,   '0, 0,   1, T2, 0);
      // Hold for 3 cycles: pipe stays {1,T2} while pc_i changes.
      step(22, 0,1,0, PC_B, 1, PC_C, T2, 1,   0, '0, 0);
      step(23, 0,1,0, '0,   1, PC_C, T2, 1,   0, '0, 0);
      step(24, 0,1,0, PC_C, 1, PC_C, T2, 1,   1, T2, 0);
      // Flush wins over hold; a later not-taken resolve is then correct.
      step(25, 0,1,1, PC_C, 0, '0,   '0, 0,   1, T2, 0);
      step(26, 0,0,0, PC_B, 1, PC_B, '0, 0,   0, '0, 0);
      // pc_jmp_i == 0 never trains: 0x1 maps to idx 0, tag 0 and must miss.
      step(27, 0,0,0, PC_A, 1, '0,   T1, 1,   1, T2, 1);
      step(28, 0,0,0, 32'h1,0, '0,   '0, 0,   0, '0, 0);
      // Reset mid-operation discards training and clears the table.
      step(29, 1,0,0, PC_A, 1, PC_A, T1, 1,   1, T2, 1);
      step(30, 0,0,0, PC_A, 0, '0,   '0, 0,   0, '0, 0);
      step(31, 0,0,0, PC_C, 0, '0,   '0, 0,   0, '0, 0);
      @(negedge clk); #1;
      if (exp_q.size() != 0) begin
         errors = errors + 1;
         checks = checks + 1;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/btb_table.md
# btb_table

Multi-entry, direct-mapped branch target buffer with a 2-bit saturating direction counter per entry. It replaces the single-entry predictor in the fetch stage. A combinational lookup on the fetch PC produces a taken prediction and a target. The prediction is carried one stage alongside the instruction and checked against the resolved outcome from execute. A mismatch raises `prediction_error_o` and trains the table.

## Interface
Parameters:
- `ADDR_W`, 32: PC and target width (matches `BUS_ADDR_MEM`).
- `ENTRIES`, 16: table depth. Must be a power of 2, ≥ 2. `IDX_W = log2(ENTRIES)`.

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `hold_i`, in, 1: pipeline hold. While 1, the prediction pipe register keeps its value.
- `flush_i`, in, 1: clears the prediction pipe register (the instruction in flight is squashed).
- `pc_i`, in, `ADDR_W`: fetch PC to look up.
- `resolve_valid_i`, in, 1: a branch or jump resolved in execute this cycle.
- `pc_jmp_i`, in, `ADDR_W`: PC of the resolved instruction.
- `target_pc_i`, in, `ADDR_W`: resolved target.
- `jmp_en_i`, in, 1: resolved taken.
- `jmp_prediction_o`, out, 1: predict taken for `pc_i`.
- `target_pc_o`, out, `ADDR_W`: predicted target. Zero when `jmp_prediction_o` = 0.
- `prediction_error_o`, out, 1: the resolved outcome disagrees with the prediction carried for this instruction.

## Operation
- Addressing:
  - `idx = pc[IDX_W+1:2]`.
  - `tag = pc[ADDR_W-1:IDX_W+2]`.
  - PC bits [1:0] are ignored.
- Entry contents: `valid`, `tag`, `target[ADDR_W]`, `ctr[2]`.
- Counter encoding:
  - 00 = strong not-taken
  - 01 = weak not-taken
  - 10 = weak taken
  - 11 = strong taken
- Lookup (combinational):
  - `hit = valid[idx] && tag match && pc_i != 0`.
  - `jmp_prediction_o = hit && ctr[idx][1]`.
  - `target_pc_o = jmp_prediction_o ? target[idx] : 0`.
- Prediction pipe register `{pred_t, tgt_t}` has three update cases:
  - `rst` or `flush_i`: set to {0, 0}.
  - else if `!hold_i`: load {`jmp_prediction_o`, `target_pc_o`}.
  - else: hold.
- Error, asserted only when `resolve_valid_i` = 1:
  - Error if `jmp_en_i != pred_t`.
  - Or error if `jmp_en_i && target_pc_i != tgt_t`.
  - Otherwise 0. Purely combinational from inputs and the pipe register.
- Training happens when `resolve_valid_i` = 1. Hit/miss is evaluated on `pc_jmp_i` against the current table:
  - Taken, hit: `ctr` saturating +1; `target` ← `target_pc_i`.
  - Taken, miss: allocate. `valid` ← 1, `tag` ← tag(`pc_jmp_i`), `target` ← `target_pc_i`, `ctr` ← 10. Any existing entry at that index is replaced.
  - Not-taken, hit: `ctr` saturating −1. The entry stays valid.
  - Not-taken, miss: no change.
  - `pc_jmp_i` = 0 never trains.
- Training is independent of `hold_i` and `flush_i`. Execute drives `resolve_valid_i` low while it is stalled.

## Timing
- Lookup latency 0: outputs are combinational from `pc_i` and the table.
- Table write latency 1: an update in cycle N is visible to lookups from cycle N+1.
- Same index looked up and trained in one cycle: the lookup sees the old contents. No bypass.
- Reset values, applied on the first edge with `rst` = 1:
  - All `valid` = 0, all `ctr` = 01, pipe register = {0, 0}.
  - Therefore `jmp_prediction_o` = 0, `target_pc_o` = 0, and `prediction_error_o` = 0 unless `resolve_valid_i` is high.
- `rst` asserted mid-operation: training in that cycle is discarded and reset wins.
- `flush_i` and `hold_i` both high: flush wins.
- Counter saturation: 11 + 1 = 11; 00 − 1 = 00. No wrap.

## Structure
- Constants go in `define.v`:
  - Counter states `STATE_S_HOLD`/`STATE_W_HOLD`/`STATE_W_JMP`/`STATE_S_JMP` (00/01/10/11).
  - `JMP_EN`/`JMP_DIS`, `JMP_RIGHT`/`JMP_ERROR`.
  - `BUS_PRE_STATE`.
- Sub-module `btb_counter`: combinational 2-bit saturating next-state from (`ctr`, `taken`). Instantiated once, on the training path.
- Table storage: flop arrays, not an inferred RAM, because the read is asynchronous.

## Test plan
Default parameters: `ENTRIES` = 16; 0x80000010 maps to idx 4.
- Reset, then `pc_i` = 0x80000010 → `jmp_prediction_o` = 0, `target_pc_o` = 0.
- Resolve taken 0x80000010 → 0x80000100 with `pred_t` = 0 → `prediction_error_o` = 1. The next cycle's lookup shows prediction 1, target 0x80000100, `ctr` = 10.
- Two more taken resolves → `ctr` 11 and stays 11. Three not-taken resolves → 10, 01 (prediction drops to 0), 00.
- Conflict: taken 0x80000010, then taken 0x80000050 (same idx 4, different tag) → lookup of 0x80000010 misses; 0x80000050 hits.
- Target change: entry at 0x80000010 predicts 0x80000100, resolved taken to 0x80000200 → error = 1; target updated, `ctr` incremented.
- `hold_i` = 1 for 3 cycles while `pc_i` changes → `pred_t`/`tgt_t` frozen. `flush_i` with `hold_i` → pipe register cleared, and a later not-taken resolve gives error = 0.
